// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter.
//   - Controller state encoding (IDLE, WR, RD_ISSUE, RD_CAPT).
//   - Requester id constants.
//   - Reset value of the round-robin history bit.
// The optional fixed-priority build is selected in rr_arb2 with the
// RAM_ARB_FIXED_PRIO_EN macro. Nothing in this package depends on it.
package ram_arb_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR       = 2'd1;
  localparam logic [1:0] ST_RD_ISSUE = 2'd2;
  localparam logic [1:0] ST_RD_CAPT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WR       = ST_WR,
    RD_ISSUE = ST_RD_ISSUE,
    RD_CAPT  = ST_RD_CAPT
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Requester 1 counts as the last winner after reset. This lets
  // requester 0 win the first conflict.
  localparam logic LAST_GRANT_RST = REQ1;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way request arbiter used by ram_port_arbiter.
// Ports:
//   valid0_i, valid1_i : pending requests from requester 0 / 1
//   en_i               : arbitration allowed (controller idle)
//   last_grant_i       : id of the previously accepted requester
//   gnt_id_o           : id of the winning requester
//   gnt_vld_o          : a grant is being issued this cycle
// Macro RAM_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins a
// conflict and last_grant_i is ignored. When undefined, a conflict goes
// to the requester that did not win last time.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic en_i,
  input  logic last_grant_i,
  output logic gnt_id_o,
  output logic gnt_vld_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    gnt_vld_o = en_i & (valid0_i | valid1_i);
    if (valid0_i && valid1_i) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gnt_id_o = REQ0;
`else
      gnt_id_o = (last_grant_i == REQ0) ? REQ1 : REQ0;
`endif
    end else begin
      gnt_id_o = valid1_i ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM with a tristate data bus between
// two requesters.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata    : request handshake for requester N
//   rspN_valid/rdata                  : one-cycle read response for requester N
//   ram_cs/we/oe/addr, ram_data       : RAM control pins and bidirectional bus
//   busy                              : controller is not idle
// Sequence:
//   - A write occupies the RAM for one cycle (WR).
//   - A read occupies it for two cycles (RD_ISSUE, then RD_CAPT).
//   - The read response appears in the cycle after RD_CAPT.
// Macro RAM_ARB_FIXED_PRIO_EN (handled in rr_arb2) selects fixed priority
// instead of round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;
  logic                    rvld0_q, rvld1_q;

  logic                    gnt_id, gnt_vld;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    cap0, cap1;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .en_i         (state_q == IDLE),
    .last_grant_i (last_grant_q),
    .gnt_id_o     (gnt_id),
    .gnt_vld_o    (gnt_vld)
  );

  // A grant is only issued for a valid requester while idle. A grant
  // therefore always means an accepted transfer.
  assign req0_ready = gnt_vld & (gnt_id == REQ0);
  assign req1_ready = gnt_vld & (gnt_id == REQ1);

  assign sel_we    = (gnt_id == REQ1) ? req1_we    : req0_we;
  assign sel_addr  = (gnt_id == REQ1) ? req1_addr  : req0_addr;
  assign sel_wdata = (gnt_id == REQ1) ? req1_wdata : req0_wdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d      = sel_we ? WR : RD_ISSUE;
          last_grant_d = gnt_id;
        end
      end
      WR:       state_d = IDLE;
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign cap0 = (state_q == RD_CAPT) && (id_q == REQ0);
  assign cap1 = (state_q == RD_CAPT) && (id_q == REQ1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_GRANT_RST;
      addr_q       <= '0;
      rvld0_q      <= 1'b0;
      rvld1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (gnt_vld) addr_q <= sel_addr;
      rvld0_q <= cap0;
      rvld1_q <= cap1;
      if (cap0) rdata0_q <= ram_data;
      if (cap1) rdata1_q <= ram_data;
    end
  end

  // Request payload that is only meaningful once the controller leaves
  // IDLE. It needs no reset.
  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      id_q    <= gnt_id;
      wdata_q <= sel_wdata;
    end
  end

  // RAM pins decode from registered state only.
  assign ram_cs   = (state_q != IDLE);
  assign ram_we   = (state_q == WR);
  assign ram_oe   = (state_q == RD_CAPT);
  assign ram_addr = addr_q;
  assign busy     = (state_q != IDLE);

  // The controller owns the bus only while writing. The RAM drives it only
  // in RD_CAPT.
  assign ram_data = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign rsp0_valid = rvld0_q;
  assign rsp1_valid = rvld1_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  a0 = '0, a1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0;
  logic        rdy0, rdy1, rv0, rv1;
  logic [15:0] rd0, rd1;
  logic        cs, rwe, oe, busy;
  logic [3:0]  raddr;
  wire  [15:0] ram_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0), .req0_we(we0), .req0_addr(a0), .req0_wdata(wd0),
    .rsp0_valid(rv0), .rsp0_rdata(rd0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_we(we1), .req1_addr(a1), .req1_wdata(wd1),
    .rsp1_valid(rv1), .rsp1_rdata(rd1),
    .ram_cs(cs), .ram_we(rwe), .ram_oe(oe), .ram_addr(raddr), .ram_data(ram_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM with a backdoor preload port.
  logic [15:0] ram_mem [16];
  logic [15:0] ram_dout = '0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_a = '0;
  logic [15:0] pl_d = '0;
  always @(posedge clk) begin
    if (pl_en) ram_mem[pl_a] <= pl_d;
    else if (cs) begin
      if (rwe) ram_mem[raddr] <= ram_data;
      else     ram_dout <= ram_mem[raddr];
    end
  end
  assign ram_data = (cs && oe && !rwe) ? ram_dout : 16'hzzzz;

  // Response log: cycle and data of every response pulse.
  int          rsp0_cyc[$], rsp1_cyc[$];
  logic [15:0] rsp0_dat[$], rsp1_dat[$];
  always @(negedge clk) begin
    if (rv0) begin rsp0_cyc.push_back(cyc); rsp0_dat.push_back(rd0); end
    if (rv1) begin rsp1_cyc.push_back(cyc); rsp1_dat.push_back(rd1); end
  end

  logic [15:0] ref_mem [16];

  task automatic set_req(input int n, input logic val, input logic we, input logic [3:0] addr,
                         input logic [15:0] d);
    if (n == 0) begin v0 = val; we0 = we; a0 = addr; wd0 = d; end
    else        begin v1 = val; we1 = we; a1 = addr; wd1 = d; end
  endtask

  task automatic wait_accept(input int n, input int budget, output int acc, output bit ok);
    ok = 1'b0; acc = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((n == 0) ? (v0 && rdy0) : (v1 && rdy1)) begin ok = 1'b1; acc = cyc; end
    end
    if (ok) begin
      @(posedge clk); #1;
      if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] addr, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_a = addr; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({busy, cs, rwe, oe, rv0, rv1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {busy, cs, rwe, oe, rv0, rv1});
    end
    checks++;
    if (raddr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0h required 0", raddr); end
    checks++;
    if (rd0 !== 16'h0 || rd1 !== 16'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", rd0, rd1);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_write_read();
    int tw, tr, b0, b1; bit ok;
    b0 = rsp0_cyc.size(); b1 = rsp1_cyc.size();
    set_req(0, 1'b1, 1'b1, 4'd3, 16'hBEEF);
    wait_accept(0, 20, tw, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept: got timeout required accept"); end
    set_req(0, 1'b1, 1'b0, 4'd3, 16'h0);
    wait_accept(0, 20, tr, ok);
    checks++;
    if (!ok || tr != tw + 2) begin
      errors++; $display("FAIL wr_rd_spacing: got %0d required %0d", tr - tw, 2);
    end
    wait_cycles(6);
    checks++;
    if (rsp0_cyc.size() - b0 != 1) begin
      errors++; $display("FAIL wr_rd_rsp0_count: got %0d required 1", rsp0_cyc.size() - b0);
    end else begin
      checks++;
      if (rsp0_cyc[b0] != tr + 3 || rsp0_dat[b0] !== 16'hBEEF) begin
        errors++;
        $display("FAIL wr_rd_rsp0: got cyc %0d data %h required cyc %0d data beef",
                 rsp0_cyc[b0], rsp0_dat[b0], tr + 3);
      end
    end
    checks++;
    if (rsp1_cyc.size() != b1) begin
      errors++; $display("FAIL wr_rd_rsp1_quiet: got %0d pulses required 0", rsp1_cyc.size() - b1);
    end
    checks++;
    if (ram_mem[3] !== 16'hBEEF) begin
      errors++; $display("FAIL wr_commit: got %h required beef", ram_mem[3]);
    end
  endtask

  task automatic test_conflict();
    int t0, t1, b0, b1; bit ok0, ok1;
    do_reset();
    preload(4'd1, 16'h0011);
    preload(4'd2, 16'h0022);
    b0 = rsp0_cyc.size(); b1 = rsp1_cyc.size();
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0);
    set_req(1, 1'b1, 1'b0, 4'd2, 16'h0);
    wait_accept(0, 20, t0, ok0);
    wait_accept(1, 20, t1, ok1);
    checks++;
    if (!ok0 || !ok1 || t1 != t0 + 3) begin
      errors++; $display("FAIL conflict_order: got t0=%0d t1=%0d required t1=t0+3", t0, t1);
    end
    wait_cycles(6);
    checks++;
    if (rsp0_cyc.size() - b0 != 1 || rsp1_cyc.size() - b1 != 1) begin
      errors++;
      $display("FAIL conflict_rsp_count: got %0d/%0d required 1/1",
               rsp0_cyc.size() - b0, rsp1_cyc.size() - b1);
    end else begin
      checks++;
      if (rsp0_cyc[b0] != t0 + 3 || rsp0_dat[b0] !== 16'h0011) begin
        errors++; $display("FAIL conflict_rsp0: got %h at %0d required 0011 at %0d",
                           rsp0_dat[b0], rsp0_cyc[b0], t0 + 3);
      end
      checks++;
      if (rsp1_cyc[b1] != t1 + 3 || rsp1_dat[b1] !== 16'h0022) begin
        errors++; $display("FAIL conflict_rsp1: got %h at %0d required 0022 at %0d",
                           rsp1_dat[b1], rsp1_cyc[b1], t1 + 3);
      end
    end
  endtask

  task automatic test_sustained();
    int order[$], acc[$];
    int k0, k1, expw;
    bit g0, g1;
    do_reset();
    k0 = 0; k1 = 0;
    set_req(0, 1'b1, 1'b1, 4'd0, 16'hA000);
    set_req(1, 1'b1, 1'b1, 4'd8, 16'hB000);
    for (int c = 0; c < 200 && (k0 < 8 || k1 < 8); c++) begin
      @(negedge clk);
      g0 = v0 && rdy0; g1 = v1 && rdy1;
      if (g0) begin order.push_back(0); acc.push_back(cyc); end
      if (g1) begin order.push_back(1); acc.push_back(cyc); end
      @(posedge clk); #1;
      if (g0) begin
        k0++;
        if (k0 < 8) set_req(0, 1'b1, 1'b1, 4'(k0), 16'hA000 + 16'(k0)); else v0 = 1'b0;
      end
      if (g1) begin
        k1++;
        if (k1 < 8) set_req(1, 1'b1, 1'b1, 4'(8 + k1), 16'hB000 + 16'(k1)); else v1 = 1'b0;
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    checks++;
    if (order.size() != 16) begin
      errors++; $display("FAIL sustained_count: got %0d grants required 16", order.size());
    end
    for (int i = 0; i < order.size() && i < 16; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      expw = (i < 8) ? 0 : 1;
`else
      expw = i % 2;
`endif
      checks++;
      if (order[i] != expw) begin
        errors++; $display("FAIL sustained_grant[%0d]: got %0d required %0d", i, order[i], expw);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 2) begin
          errors++; $display("FAIL sustained_spacing[%0d]: got %0d required 2", i, acc[i] - acc[i-1]);
        end
      end
    end
    wait_cycles(3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram_mem[i] !== 16'hA000 + 16'(i) || ram_mem[8+i] !== 16'hB000 + 16'(i)) begin
        errors++;
        $display("FAIL sustained_mem[%0d]: got %h/%h required %h/%h", i, ram_mem[i], ram_mem[8+i],
                 16'hA000 + 16'(i), 16'hB000 + 16'(i));
      end
    end
  endtask

  task automatic test_random();
    int nf, wr_cyc, capt_cyc, lw, w;
    int pend_cyc[2];
    logic [15:0] pend_dat[2], last_dat[2];
    logic [15:0] wr_data, d;
    logic [3:0] wr_addr, rd_addr, addr;
    logic exp_busy, g0, g1, we;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      preload(4'(i), d);
      ref_mem[i] = d;
    end
    nf = 0; wr_cyc = -1; capt_cyc = -1; lw = 1;
    pend_cyc[0] = -1; pend_cyc[1] = -1;
    last_dat[0] = 16'h0; last_dat[1] = 16'h0;
    pend_dat[0] = 16'h0; pend_dat[1] = 16'h0;
    wr_data = 16'h0; wr_addr = 4'h0; rd_addr = 4'h0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      exp_busy = (cyc < nf);
      checks++;
      if (busy !== exp_busy || cs !== exp_busy) begin
        errors++; $display("FAIL rnd_busy@%0d: got busy=%b cs=%b required %b", cyc, busy, cs, exp_busy);
      end
      checks++;
      if (rwe !== (cyc == wr_cyc) || oe !== (cyc == capt_cyc)) begin
        errors++; $display("FAIL rnd_we_oe@%0d: got we=%b oe=%b required %b/%b",
                           cyc, rwe, oe, cyc == wr_cyc, cyc == capt_cyc);
      end
      if (cyc == wr_cyc) begin
        checks++;
        if (ram_data !== wr_data || raddr !== wr_addr) begin
          errors++; $display("FAIL rnd_wr_bus@%0d: got %h@%h required %h@%h",
                             cyc, ram_data, raddr, wr_data, wr_addr);
        end
      end
      if (cyc == capt_cyc) begin
        checks++;
        if ($isunknown(ram_data) || raddr !== rd_addr) begin
          errors++; $display("FAIL rnd_rd_bus@%0d: got %h@%h required known@%h",
                             cyc, ram_data, raddr, rd_addr);
        end
      end
      checks++;
      if (rv0 !== (pend_cyc[0] == cyc) || rv1 !== (pend_cyc[1] == cyc)) begin
        errors++; $display("FAIL rnd_rsp_valid@%0d: got %b%b required %b%b",
                           cyc, rv0, rv1, pend_cyc[0] == cyc, pend_cyc[1] == cyc);
      end
      if (pend_cyc[0] == cyc) last_dat[0] = pend_dat[0];
      if (pend_cyc[1] == cyc) last_dat[1] = pend_dat[1];
      checks++;
      if (rd0 !== last_dat[0] || rd1 !== last_dat[1]) begin
        errors++; $display("FAIL rnd_rdata@%0d: got %h/%h required %h/%h",
                           cyc, rd0, rd1, last_dat[0], last_dat[1]);
      end
      g0 = v0 && rdy0; g1 = v1 && rdy1;
      w = -1;
      if (!exp_busy && (v0 || v1)) begin
        if (v0 && v1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = (lw == 0) ? 1 : 0;
`endif
        end else w = v0 ? 0 : 1;
      end
      checks++;
      if (g0 !== (w == 0) || g1 !== (w == 1)) begin
        errors++; $display("FAIL rnd_grant@%0d: got %b%b required winner %0d", cyc, g0, g1, w);
      end
      if (w >= 0) begin
        lw = w;
        we   = (w == 0) ? we0 : we1;
        addr = (w == 0) ? a0 : a1;
        d    = (w == 0) ? wd0 : wd1;
        if (we) begin
          nf = cyc + 2; wr_cyc = cyc + 1; wr_data = d; wr_addr = addr;
          ref_mem[addr] = d;
        end else begin
          nf = cyc + 3; capt_cyc = cyc + 2; rd_addr = addr;
          pend_cyc[w] = cyc + 3; pend_dat[w] = ref_mem[addr];
        end
      end
      @(posedge clk); #1;
      if (g0) v0 = 1'b0;
      if (g1) v1 = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (((n == 0) ? !v0 : !v1) && $urandom_range(0, 3) != 0)
          set_req(n, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_reset_mid_read();
    int t, b0, b1; bit ok;
    preload(4'd4, 16'h1234);
    b0 = rsp0_cyc.size(); b1 = rsp1_cyc.size();
    set_req(1, 1'b1, 1'b0, 4'd4, 16'h0);
    wait_accept(1, 20, t, ok);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || cs !== 1'b1 || oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_issue: got ok=%b busy=%b cs=%b oe=%b required 1/1/1/0",
                         ok, busy, cs, oe);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cs !== 1'b0 || busy !== 1'b0 || oe !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got cs=%b busy=%b oe=%b required 0/0/0", cs, busy, oe);
    end
    wait_cycles(6);
    checks++;
    if (rsp0_cyc.size() != b0 || rsp1_cyc.size() != b1) begin
      errors++; $display("FAIL rstmid_no_rsp: got %0d/%0d pulses required 0/0",
                         rsp0_cyc.size() - b0, rsp1_cyc.size() - b1);
    end
    set_req(0, 1'b1, 1'b0, 4'd4, 16'h0);
    wait_accept(0, 20, t, ok);
    wait_cycles(5);
    checks++;
    if (!ok || rsp0_cyc.size() - b0 != 1) begin
      errors++; $display("FAIL rstmid_next_req: got ok=%b pulses=%0d required 1/1", ok, rsp0_cyc.size() - b0);
    end else begin
      checks++;
      if (rsp0_cyc[b0] != t + 3 || rsp0_dat[b0] !== 16'h1234) begin
        errors++; $display("FAIL rstmid_next_data: got %h at %0d required 1234 at %0d",
                           rsp0_dat[b0], rsp0_cyc[b0], t + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int tw, tr, b0, b1; bit okw, okr;
    do_reset();
    preload(4'd15, 16'h0000);
    b0 = rsp0_cyc.size(); b1 = rsp1_cyc.size();
    set_req(0, 1'b1, 1'b1, 4'd15, 16'hFFFF);
    set_req(1, 1'b1, 1'b0, 4'd15, 16'h0);
    wait_accept(0, 20, tw, okw);
    wait_accept(1, 20, tr, okr);
    checks++;
    if (!okw || !okr || tr != tw + 2) begin
      errors++; $display("FAIL b2b_order: got tw=%0d tr=%0d required tr=tw+2", tw, tr);
    end
    wait_cycles(6);
    checks++;
    if (rsp1_cyc.size() - b1 != 1 || rsp0_cyc.size() != b0) begin
      errors++; $display("FAIL b2b_rsp_count: got %0d/%0d required 0/1",
                         rsp0_cyc.size() - b0, rsp1_cyc.size() - b1);
    end else begin
      checks++;
      if (rsp1_cyc[b1] != tr + 3 || rsp1_dat[b1] !== 16'hFFFF) begin
        errors++; $display("FAIL b2b_data: got %h at %0d required ffff at %0d",
                           rsp1_dat[b1], rsp1_cyc[b1], tr + 3);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_sustained();
    test_random();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
